// File: rtl/single_port_ram_if.sv
// Bus bundle for single_port_ram: write enable, shared address, write data and read data.
// The master drives the request fields and the RAM (slave) drives q.
interface single_port_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] q;

    modport master (
        output we,
        output addr,
        output data,
        input  q
    );

    modport slave (
        input  we,
        input  addr,
        input  data,
        output q
    );
endinterface

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM with a registered, write-first read port and unreset storage.
// Define SPRAM_OUT_REG_EN to add a second output register stage (2-cycle read latency).
module single_port_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input logic              clk,
    input logic              rst_n,
    single_port_ram_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] addr_x;
    logic                  mem_we;

    // Reduces to X in simulation when addr carries X/Z; the xor pair cancels in hardware.
    assign addr_x = {DATA_WIDTH{^bus.addr}};
    assign mem_we = bus.we & rst_n;

    always_comb begin
        rd_d = mem[bus.addr];
        if (bus.we) begin
            rd_d = bus.data ^ addr_x ^ addr_x;
        end
    end

    // Storage has no reset so it maps onto a block-RAM primitive.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.addr] <= bus.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

`ifdef SPRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = rd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.q = out_q;
`else
    assign bus.q = rd_q;
`endif
endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: table-driven vectors plus fill and reset sequences,
// with expected read data queued at drive time and popped when the output is due.
module tb_single_port_ram;
    localparam int DW = 8;
    localparam int AW = 6;
`ifdef SPRAM_OUT_REG_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    single_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    single_port_ram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        chk;
        logic [7:0]  exp;
        string       name;
    } sb_t;

    typedef struct {
        logic        we;
        logic [5:0]  addr;
        logic [7:0]  data;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    sb_t        sb[$];
    vec_t       vec[17];
    logic [7:0] fill_data[64];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One access per cycle: drive on the falling edge, compare whatever output is due now.
    task automatic access(input logic w, input logic [5:0] a, input logic [7:0] d,
                          input logic chk, input logic [7:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        bus.we   = w;
        bus.addr = a;
        bus.data = d;
        e.chk  = chk;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= Lat) begin
            e = sb.pop_front();
            if (e.chk) check(e.name, bus.q, e.exp);
        end
    endtask

    task automatic flush();
        repeat (Lat - 1) access(1'b0, 6'd0, 8'h00, 1'b0, 8'h00, "flush");
    endtask

    initial begin
        vec[0] = '{1'b1, 6'd5, 8'hA5, 8'hA5, "wf_write"};
        vec[1] = '{1'b0, 6'd5, 8'h00, 8'hA5, "wf_read"};
        vec[2] = '{1'b1, 6'd63, 8'h3C, 8'h3C, "ro_write"};
        for (int i = 3; i < 13; i++) vec[i] = '{1'b0, 6'd63, 8'hFF, 8'h3C, "ro_read"};
        vec[13] = '{1'b1, 6'd0, 8'h80, 8'h80, "bnd_w0"};
        vec[14] = '{1'b1, 6'd63, 8'h7F, 8'h7F, "bnd_w63"};
        vec[15] = '{1'b0, 6'd63, 8'h00, 8'h7F, "bnd_r63"};
        vec[16] = '{1'b0, 6'd0, 8'h00, 8'h80, "bnd_r0"};
        for (int i = 0; i < 64; i++) fill_data[i] = 8'($urandom_range(0, 255));

        bus.we   = 1'b0;
        bus.addr = '0;
        bus.data = '0;
        #12;
        check("reset_q", bus.q, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_q", bus.q, 8'h00);

        // Fill test
        for (int i = 0; i < 64; i++) begin
            access(1'b1, 6'(i), fill_data[i], 1'b1, fill_data[i], "fill_write");
`ifdef SPRAM_OUT_REG_EN
            if (i == 0) check("first_edge_q", bus.q, 8'h00);
`endif
        end
        for (int i = 0; i < 64; i++)
            access(1'b0, 6'(i), 8'h00, 1'b1, fill_data[i], "fill_read");
        flush();

        // Write-first, read-only and boundary vectors
        for (int i = 0; i < 17; i++)
            access(vec[i].we, vec[i].addr, vec[i].data, 1'b1, vec[i].exp, vec[i].name);
        flush();

        // Reset in mid-sequence with a write pending
        access(1'b1, 6'd0, 8'h11, 1'b1, 8'h11, "rst_w0");
        access(1'b1, 6'd1, 8'h22, 1'b1, 8'h22, "rst_w1");
        repeat (Lat) access(1'b0, 6'd1, 8'h00, 1'b1, 8'h22, "rst_pre_read");
        sb.delete();
        @(negedge clk);
        bus.we   = 1'b1;
        bus.addr = 6'd1;
        bus.data = 8'h99;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_q", bus.q, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_q", bus.q, 8'h00);
        @(negedge clk);
        bus.we = 1'b0;
        rst_n  = 1'b1;
        #1;
        check("rst_release_q", bus.q, 8'h00);
        access(1'b0, 6'd1, 8'h00, 1'b1, 8'h22, "rst_read1");
        access(1'b0, 6'd0, 8'h00, 1'b1, 8'h11, "rst_read0");
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
